// File: rtl/serial_memory_loader_pkg.sv
// Shared definitions for the serial memory loader.
//   - Memory port mode encodings (only NONE and WORD are driven by the loader)
//   - Command and reply byte values of the host protocol
//   - FSM state enum
package serial_memory_loader_pkg;

  // Memory port access modes
  localparam logic [2:0] MODE_NONE     = 3'd0;
  localparam logic [2:0] MODE_BYTE     = 3'd1;
  localparam logic [2:0] MODE_HALFWORD = 3'd2;
  localparam logic [2:0] MODE_WORD     = 3'd3;

  // Host command bytes
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_GO    = 8'h47;  // 'G'
  localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'

  // Reply bytes
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_READ_WAIT,
    S_REPLY
  } loader_state_t;

  // A command byte that leads into the address phase
  function automatic logic is_mem_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/serial_memory_loader.sv
// Byte-command front end for the processor's external memory port.
// A host sends commands over the UART receive byte stream; this block
// writes/reads memory words, halts/releases the core and answers on the
// transmit byte stream.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_valid, rx_data        received byte strobe and value
//   tx_valid, tx_data,       reply byte, held until tx_ready
//   tx_ready
//   pause                    1 = processor halted
//   externalMemoryControl    1 = memory port owned by this block
//   externalAddress/Data     memory byte address and write data
//   externalReadMode/        memory access modes (NONE or WORD)
//   externalWriteMode
//   externalDataOut          memory read data
//   busy                     1 while a command is in progress
//   overrun                  one-cycle pulse when an rx byte was dropped
//
// State        | meaning
// -------------+-----------------------------------------------------
// S_IDLE       | waiting for a command byte
// S_ADDR       | collecting 4 address bytes, MSB first
// S_DATA       | collecting 4 write data bytes, MSB first
// S_WRITE      | single WORD write cycle on the memory port
// S_READ_WAIT  | WORD read held READ_LATENCY+1 cycles, data captured on last
// S_REPLY      | sending 1 or 4 reply bytes, advancing on tx handshake
module serial_memory_loader
  import serial_memory_loader_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        pause,
  output logic        externalMemoryControl,
  output logic [31:0] externalAddress,
  output logic [31:0] externalData,
  output logic [2:0]  externalReadMode,
  output logic [2:0]  externalWriteMode,
  input  logic [31:0] externalDataOut,
  output logic        busy,
  output logic        overrun
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  // Timer is reloaded on every byte; reaching zero with no byte means
  // TIMEOUT_CYCLES idle cycles have elapsed.
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] WAIT_LOAD  = LW'(READ_LATENCY);

  loader_state_t state, state_nxt;

  logic [1:0]    byte_cnt;
  logic          is_write;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [31:0]   reply_q;
  logic [1:0]    reply_left;
  logic [TW-1:0] timer;
  logic [LW-1:0] wait_cnt;
  logic          pause_q;
  logic          memctrl_q;
  logic          overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    tx_valid          = 1'b0;
    tx_data           = 8'h00;
    externalReadMode  = MODE_NONE;
    externalWriteMode = MODE_NONE;
    busy              = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (rx_valid) state_nxt = is_mem_cmd(rx_data) ? S_ADDR : S_REPLY;
      end
      S_ADDR: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_nxt = is_write ? S_DATA : S_READ_WAIT;
        end else if (timer == '0) begin
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_nxt = S_WRITE;
        end else if (timer == '0) begin
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        externalWriteMode = MODE_WORD;
        state_nxt         = S_REPLY;
      end
      S_READ_WAIT: begin
        externalReadMode = MODE_WORD;
        if (wait_cnt == '0) state_nxt = S_REPLY;
      end
      S_REPLY: begin
        tx_valid = 1'b1;
        tx_data  = reply_q[31:24];
        if (tx_ready && (reply_left == 2'd0)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      is_write   <= 1'b0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      reply_q    <= 32'h0;
      reply_left <= 2'd0;
      timer      <= TIMER_LOAD;
      wait_cnt   <= WAIT_LOAD;
      pause_q    <= 1'b1;
      memctrl_q  <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= rx_valid &&
                   ((state == S_WRITE) || (state == S_READ_WAIT) || (state == S_REPLY));
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            byte_cnt   <= 2'd0;
            timer      <= TIMER_LOAD;
            reply_left <= 2'd0;
            case (rx_data)
              CMD_WRITE: begin
                is_write  <= 1'b1;
                pause_q   <= 1'b1;
                memctrl_q <= 1'b1;
              end
              CMD_READ: begin
                is_write  <= 1'b0;
                pause_q   <= 1'b1;
                memctrl_q <= 1'b1;
              end
              CMD_GO: begin
                pause_q   <= 1'b0;
                memctrl_q <= 1'b0;
                reply_q   <= {RSP_ACK, 24'h0};
              end
              CMD_PAUSE: begin
                pause_q   <= 1'b1;
                memctrl_q <= 1'b1;
                reply_q   <= {RSP_ACK, 24'h0};
              end
              default: reply_q <= {RSP_NAK, 24'h0};
            endcase
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q   <= {addr_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            timer    <= TIMER_LOAD;
            wait_cnt <= WAIT_LOAD;
          end else if (timer != '0) begin
            timer <= timer - TW'(1);
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            data_q   <= {data_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            timer    <= TIMER_LOAD;
          end else if (timer != '0) begin
            timer <= timer - TW'(1);
          end
        end
        S_WRITE: begin
          reply_q    <= {RSP_ACK, 24'h0};
          reply_left <= 2'd0;
        end
        S_READ_WAIT: begin
          if (wait_cnt == '0) begin
            reply_q    <= externalDataOut;
            reply_left <= 2'd3;
          end else begin
            wait_cnt <= wait_cnt - LW'(1);
          end
        end
        S_REPLY: begin
          // Reply bytes leave MSB first, so shift the next one into the top byte
          if (tx_ready) begin
            reply_q <= {reply_q[23:0], 8'h00};
            if (reply_left != 2'd0) reply_left <= reply_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pause                 = pause_q;
  assign externalMemoryControl = memctrl_q;
  assign externalAddress       = addr_q;
  assign externalData          = data_q;
  assign overrun               = overrun_q;

endmodule

// File: tb/tb_serial_memory_loader.sv
module tb_serial_memory_loader;
  import serial_memory_loader_pkg::*;

  localparam int unsigned RL = 1;
  localparam int unsigned TO = 40;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        pause;
  logic        externalMemoryControl;
  logic [31:0] externalAddress;
  logic [31:0] externalData;
  logic [2:0]  externalReadMode;
  logic [2:0]  externalWriteMode;
  logic [31:0] externalDataOut = 32'h0;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  serial_memory_loader #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pause(pause), .externalMemoryControl(externalMemoryControl),
    .externalAddress(externalAddress), .externalData(externalData),
    .externalReadMode(externalReadMode), .externalWriteMode(externalWriteMode),
    .externalDataOut(externalDataOut), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Memory with one cycle read latency
  logic [31:0] mem [bit [31:0]];
  always @(posedge clk) begin
    if (externalReadMode == MODE_WORD)
      externalDataOut <= mem.exists(externalAddress) ? mem[externalAddress] : 32'h0;
    if (externalWriteMode == MODE_WORD) mem[externalAddress] = externalData;
  end

  // Monitor
  int          cyc = 0;
  logic [7:0]  txq[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc = -1, last_rx_cyc = -1, first_tx_cyc = -1;
  logic        tx_prev = 1'b0;
  int          n_overrun = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (externalWriteMode == MODE_WORD) begin
      wr_addr_q.push_back(externalAddress);
      wr_data_q.push_back(externalData);
      wr_cyc = cyc;
    end
    if (rx_valid) last_rx_cyc = cyc;
    if (tx_valid && !tx_prev) first_tx_cyc = cyc;
    tx_prev = tx_valid;
    if (overrun) n_overrun++;
  end

  // Reference model: protocol rules in plain arithmetic
  logic [31:0] ref_mem [bit [31:0]];
  logic        ref_pause = 1'b1;

  task automatic model_cmd(input byte_q_t cmd, output byte_q_t exp,
                           output logic exp_wr, output logic [31:0] ea,
                           output logic [31:0] ed);
    logic [31:0] v;
    exp = {};
    exp_wr = 1'b0;
    ea = 32'h0;
    ed = 32'h0;
    if (cmd.size() >= 5) ea = {cmd[1], cmd[2], cmd[3], cmd[4]};
    if (cmd.size() >= 9) ed = {cmd[5], cmd[6], cmd[7], cmd[8]};
    case (cmd[0])
      8'h57: begin
        ref_mem[ea] = ed;
        exp_wr = 1'b1;
        ref_pause = 1'b1;
        exp.push_back(8'h06);
      end
      8'h52: begin
        v = ref_mem.exists(ea) ? ref_mem[ea] : 32'h0;
        ref_pause = 1'b1;
        for (int k = 3; k >= 0; k--) exp.push_back(8'((v >> (8 * k)) & 32'hFF));
      end
      8'h47: begin ref_pause = 1'b0; exp.push_back(8'h06); end
      8'h50: begin ref_pause = 1'b1; exp.push_back(8'h06); end
      default: exp.push_back(8'h15);
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s idle_timeout: busy=%0b required 0", name, busy);
    end
  endtask

  task automatic clear_mon();
    txq.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_tx(input string name, input byte_q_t exp);
    n_checks++;
    if (txq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL %s tx_count: got %0d required %0d", name, txq.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        n_checks++;
        if (txq[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL %s tx_byte%0d: got %02h required %02h", name, i, txq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic run_cmd(input string name, input byte_q_t cmd, input int max_gap);
    byte_q_t exp;
    logic exp_wr;
    logic [31:0] ea, ed;
    model_cmd(cmd, exp, exp_wr, ea, ed);
    clear_mon();
    foreach (cmd[i]) send_byte(cmd[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    wait_idle(name);
    check_tx(name, exp);
    n_checks++;
    if (wr_addr_q.size() != (exp_wr ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_addr_q.size(), exp_wr ? 1 : 0);
    end else if (exp_wr) begin
      n_checks++;
      if (wr_addr_q[0] !== ea || wr_data_q[0] !== ed) begin
        n_fail++;
        $display("FAIL %s write: got %08h/%08h required %08h/%08h",
                 name, wr_addr_q[0], wr_data_q[0], ea, ed);
      end
    end
    n_checks++;
    if (pause !== ref_pause || externalMemoryControl !== ref_pause) begin
      n_fail++;
      $display("FAIL %s pause: got %0b/%0b required %0b", name, pause, externalMemoryControl, ref_pause);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if (pause !== 1'b1 || externalMemoryControl !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pause: got %0b/%0b required 1/1", name, pause, externalMemoryControl);
    end
    n_checks++;
    if (externalReadMode !== MODE_NONE || externalWriteMode !== MODE_NONE) begin
      n_fail++;
      $display("FAIL %s modes: got %0d/%0d required NONE", name, externalReadMode, externalWriteMode);
    end
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL %s flags: got tx_valid=%0b tx_data=%02h busy=%0b overrun=%0b required 0",
               name, tx_valid, tx_data, busy, overrun);
    end
    n_checks++;
    if (externalAddress !== 32'h0 || externalData !== 32'h0) begin
      n_fail++;
      $display("FAIL %s addr_data: got %08h/%08h required 0/0", name, externalAddress, externalData);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
  endtask

  task automatic test_write();
    run_cmd("write", '{8'h57, 8'h00, 8'h00, 8'h04, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0);
    n_checks++;
    if (wr_cyc != last_rx_cyc + 1) begin
      n_fail++;
      $display("FAIL write_latency: got %0d required %0d", wr_cyc - last_rx_cyc, 1);
    end
    n_checks++;
    if (first_tx_cyc != wr_cyc + 1) begin
      n_fail++;
      $display("FAIL ack_latency: got %0d required %0d", first_tx_cyc - wr_cyc, 1);
    end
  endtask

  task automatic test_read_stall();
    byte_q_t cmd, exp;
    logic ew;
    logic [31:0] ea, ed;
    cmd = '{8'h52, 8'h00, 8'h00, 8'h04, 8'h00};
    model_cmd(cmd, exp, ew, ea, ed);
    clear_mon();
    tx_ready = 1'b0;
    foreach (cmd[i]) send_byte(cmd[i], 0);
    for (int k = 0; k < 50 && !tx_valid; k++) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp[b]) begin
          n_fail++;
          $display("FAIL stall_byte%0d: got valid=%0b data=%02h required 1/%02h",
                   b, tx_valid, tx_data, exp[b]);
        end
      end
      @(posedge clk); #1 tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_idle("read_stall");
    check_tx("read_stall", exp);
  endtask

  task automatic test_go_read();
    mem[32'h5020] = 32'h1357_9BDF;
    ref_mem[32'h5020] = 32'h1357_9BDF;
    run_cmd("go", '{8'h47}, 0);
    n_checks++;
    if (pause !== 1'b0 || externalMemoryControl !== 1'b0) begin
      n_fail++;
      $display("FAIL go_release: got %0b/%0b required 0/0", pause, externalMemoryControl);
    end
    begin
      byte_q_t cmd, exp;
      logic ew;
      logic [31:0] ea, ed;
      cmd = '{8'h52, 8'h00, 8'h00, 8'h50, 8'h20};
      model_cmd(cmd, exp, ew, ea, ed);
      clear_mon();
      send_byte(cmd[0], 0);
      n_checks++;
      if (pause !== 1'b1 || externalMemoryControl !== 1'b1) begin
        n_fail++;
        $display("FAIL implicit_pause: got %0b/%0b required 1/1", pause, externalMemoryControl);
      end
      for (int i = 1; i < 5; i++) send_byte(cmd[i], 1);
      wait_idle("read_running");
      check_tx("read_running", exp);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    repeat (TO / 2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: busy=%0b required 1", busy);
    end
    repeat (TO) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr_addr_q.size() != 0 || txq.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_abort: busy=%0b writes=%0d tx=%0d required 0/0/0",
               busy, wr_addr_q.size(), txq.size());
    end
    n_checks++;
    if (pause !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pause: got %0b required 1", pause);
    end
    run_cmd("nak", '{8'h99}, 0);
  endtask

  task automatic test_overrun();
    int ov0;
    byte_q_t exp;
    logic ew;
    logic [31:0] ea, ed;
    model_cmd('{8'h50}, exp, ew, ea, ed);
    clear_mon();
    tx_ready = 1'b0;
    ov0 = n_overrun;
    send_byte(8'h50, 0);
    send_byte(8'h41, 1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (n_overrun - ov0 != 1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %0d pulses required 1", n_overrun - ov0);
    end
    tx_ready = 1'b1;
    wait_idle("overrun");
    check_tx("overrun", exp);
  endtask

  task automatic test_reset_mid();
    run_cmd("go2", '{8'h47}, 0);
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAB, 0);
    #2 rst = 1'b1;
    #1 check_reset_values("reset_mid");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    ref_pause = 1'b1;
    run_cmd("after_reset",
            '{8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'hCA, 8'hFE, 8'h12, 8'h34}, 0);
  endtask

  task automatic test_random();
    logic [31:0] addrs [4];
    addrs[0] = 32'h0000_0400;
    addrs[1] = 32'h0000_5020;
    addrs[2] = 32'h0000_0101;
    addrs[3] = 32'h8000_0010;
    for (int n = 0; n < 40; n++) begin
      byte_q_t cmd;
      logic [31:0] a, d;
      logic [7:0] u;
      a = addrs[$urandom_range(0, 3)];
      d = $urandom;
      cmd = {};
      case ($urandom_range(0, 5))
        0, 1: cmd = '{8'h57, a[31:24], a[23:16], a[15:8], a[7:0],
                      d[31:24], d[23:16], d[15:8], d[7:0]};
        2, 3: cmd = '{8'h52, a[31:24], a[23:16], a[15:8], a[7:0]};
        4:    cmd = ($urandom_range(0, 1) == 0) ? '{8'h47} : '{8'h50};
        default: begin
          u = 8'($urandom_range(0, 255));
          if (u == 8'h57 || u == 8'h52 || u == 8'h47 || u == 8'h50) u = 8'h00;
          cmd = '{u};
        end
      endcase
      run_cmd("random", cmd, 3);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_go_read();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
